// File: rtl/aes_pkg.sv
// Shared AES-128 constants: widths, round count, round constants and the S-box table.
// Combinational lookups only; no state and no flow control.
package aes_pkg;

  localparam int BLOCK_DATA_WIDTH = 128;
  localparam int SEED_KEY_WIDTH   = 128;
  localparam int NUM_ROUNDS       = 10;

  typedef logic [31:0] word_t;

  // Index r holds rcon for round r; index 0 and the tail past round 10 are unused padding.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, 8-bit in to 8-bit out.
// Purely combinational (0 cycles); no flow control.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/add_round_key_block.sv
// AES-128 AddRoundKey with on-the-fly key schedule; 1-cycle latency, no backpressure.
// Define ARK_ROUND_IDX_OUT_EN to expose the round register as round_idx.
module add_round_key_block
  import aes_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [BLOCK_DATA_WIDTH-1:0] data_in,
  input  logic                        data_in_vld,
  input  logic [SEED_KEY_WIDTH-1:0]   seed_key,
  input  logic                        seed_key_vld,
`ifdef ARK_ROUND_IDX_OUT_EN
  output logic [3:0]                  round_idx,
`endif
  output logic [BLOCK_DATA_WIDTH-1:0] block_data_out,
  output logic                        block_data_out_vld
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [SEED_KEY_WIDTH-1:0]   key_q, key_d;
  logic [SEED_KEY_WIDTH-1:0]   seed_q, seed_d;
  logic [3:0]                  round_q, round_d;
  logic [BLOCK_DATA_WIDTH-1:0] out_q, out_d;
  logic                        out_vld_q, out_vld_d;

  logic [SEED_KEY_WIDTH-1:0] eff_key;
  logic [3:0]                eff_round;
  logic [3:0]                rcon_idx;
  word_t                     w0, w1, w2, w3;
  word_t                     rot_w, sub_w, t_w;
  word_t                     n0, n1, n2, n3;

  // A seed arriving this cycle overrides the held key so a same-cycle beat uses it as round 0.
  assign eff_key   = seed_key_vld ? seed_key : key_q;
  assign eff_round = seed_key_vld ? 4'd0 : round_q;
  assign rcon_idx  = (eff_round == LAST_ROUND) ? 4'd0 : eff_round + 4'd1;

  assign {w0, w1, w2, w3} = eff_key;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .byte_i (rot_w[8*g +: 8]),
      .byte_o (sub_w[8*g +: 8])
    );
  end

  assign t_w = sub_w ^ {RCON[rcon_idx], 24'h0};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  always_comb begin
    key_d     = key_q;
    seed_d    = seed_q;
    round_d   = round_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    if (seed_key_vld) begin
      seed_d  = seed_key;
      key_d   = seed_key;
      round_d = 4'd0;
    end
    if (data_in_vld) begin
      out_d     = data_in ^ eff_key;
      out_vld_d = 1'b1;
      // Past the last round the schedule restarts from the saved seed for the next block.
      if (eff_round == LAST_ROUND) begin
        key_d   = seed_q;
        round_d = 4'd0;
      end else begin
        key_d   = {n0, n1, n2, n3};
        round_d = eff_round + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q     <= '0;
      seed_q    <= '0;
      round_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      seed_q    <= seed_d;
      round_q   <= round_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign block_data_out     = out_q;
  assign block_data_out_vld = out_vld_q;
`ifdef ARK_ROUND_IDX_OUT_EN
  assign round_idx = round_q;
`endif

endmodule

// File: tb/tb_add_round_key_block.sv
// Randomized scoreboard bench for add_round_key_block against a GF(2^8)-derived AES key-schedule model.
module tb_add_round_key_block;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] data_in = '0;
  logic         data_in_vld = 1'b0;
  logic [127:0] seed_key = '0;
  logic         seed_key_vld = 1'b0;
  logic [127:0] block_data_out;
  logic         block_data_out_vld;
`ifdef ARK_ROUND_IDX_OUT_EN
  logic [3:0]   round_idx;
`endif

  add_round_key_block dut (
    .clock              (clock),
    .reset              (reset),
    .data_in            (data_in),
    .data_in_vld        (data_in_vld),
    .seed_key           (seed_key),
    .seed_key_vld       (seed_key_vld),
`ifdef ARK_ROUND_IDX_OUT_EN
    .round_idx          (round_idx),
`endif
    .block_data_out     (block_data_out),
    .block_data_out_vld (block_data_out_vld)
  );

  always #5 clock = ~clock;

  localparam logic [127:0] SEED = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] hold_exp = '0;
  logic [7:0]   sb [0:255];
  logic [127:0] m_rk [0:10];
  int           m_round = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_keys(input logic [127:0] seed);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = seed[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic ld, input logic [127:0] sk, input logic dv,
                       input logic [127:0] din, input logic ovr, input logic [127:0] oexp);
    @(posedge clock); #2;
`ifdef ARK_ROUND_IDX_OUT_EN
    check("round_idx", {124'h0, round_idx}, 128'(m_round));
`endif
    seed_key_vld = ld;
    seed_key     = sk;
    data_in_vld  = dv;
    data_in      = din;
    if (ld) begin
      compute_keys(sk);
      m_round = 0;
    end
    if (dv) begin
      exp_q.push_back(ovr ? oexp : (din ^ m_rk[m_round]));
      m_round = (m_round == 10) ? 0 : m_round + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // A beat presented in the reset cycle must be dropped.
  task automatic do_reset();
    idle(1);
    @(posedge clock); #2;
    reset        = 1'b1;
    seed_key_vld = 1'b0;
    data_in_vld  = 1'b1;
    data_in      = rnd128();
    @(posedge clock); #2;
    reset       = 1'b0;
    data_in_vld = 1'b0;
    compute_keys('0);
    m_round  = 0;
    hold_exp = '0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (block_data_out_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_vld: got vld=1 with out %h, expected vld=0", block_data_out);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          check("data_out", block_data_out, e);
          hold_exp = e;
        end
      end else begin
        check("hold_out", block_data_out, hold_exp);
      end
    end
  end

  initial begin
    build_sbox();
    compute_keys('0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    idle(3);

    // FIPS-197 Appendix B vector.
    drive(1'b1, SEED, 1'b0, '0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 128'h3243f6a8885a308d313198a2e0370734, 1'b1,
          128'h193de3bea0f4e22b9ac68d2ae9f84808);

    drive(1'b1, SEED, 1'b0, '0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, '0, 1'b1, SEED);
    drive(1'b0, '0, 1'b1, '0, 1'b1, RK1);

    // Full schedule then wrap back to the seed.
    drive(1'b1, SEED, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 12; i++)
      drive(1'b0, '0, 1'b1, '0, (i == 0 || i == 1 || i == 10 || i == 11),
            (i == 1) ? RK1 : (i == 10) ? RK10 : SEED);

    drive(1'b1, SEED, 1'b1, '0, 1'b1, SEED);
    idle(3);
    drive(1'b0, '0, 1'b1, '0, 1'b1, RK1);

    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, rnd128(), 1'b0, '0);
    do_reset();
    begin
      logic [127:0] d;
      d = rnd128();
      drive(1'b0, '0, 1'b1, d, 1'b1, d);
    end

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 120) == 0) begin
        do_reset();
      end else begin
        logic ld, dv;
        ld = ($urandom_range(0, 7) == 0);
        dv = ($urandom_range(0, 2) != 0);
        drive(ld, rnd128(), dv, rnd128(), 1'b0, '0);
      end
    end

    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
